// File: rtl/mux_4_1_rr_arbiter.sv
// Purpose : round-robin arbiter sharing one 4:1 mux between four valid/ready requesters.
// Latency : 1 cycle from input transfer to out_valid; 1 word/cycle when out_ready is held high.
// Backpr. : in_ready is zero while the output register is full and out_ready is low.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid[3:0]            per-requester valid
//   in_data0..in_data3       per-requester data (WIDTH bits)
//   in_ready[3:0]            per-requester accept (one-hot or zero)
//   out_valid/out_ready      output register handshake
//   out_data, out_sel        registered winning data and the index it came from
//
// Build option: define MUX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// no last-grant pointer). Default build is round-robin.
module mux_4_1_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  logic             can_accept;
  logic [1:0]       search_base;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] mux_dat;

  // A full register may drain and reload in the same cycle.
  assign can_accept = !out_valid || out_ready;

`ifdef MUX_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at requester 0.
  assign search_base = 2'd0;
`else
  logic [1:0] last_grant;

  // Search starts one past the last winner; the 2-bit add wraps 3 -> 0.
  assign search_base = last_grant + 2'd1;

  // Pointer moves only on a transfer so idle cycles do not rotate priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 2'd3;
    end else if (transfer) begin
      last_grant <= grant_idx;
    end
  end
`endif

  // First set in_valid bit in search order from search_base.
  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = search_base + 2'(k);
      if (!grant_vld && in_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // The winner is valid by construction, so transfer needs only space.
  assign transfer = grant_vld && can_accept;

  always_comb begin
    in_ready = 4'b0000;
    if (transfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    mux_dat = in_data0;
      2'd1:    mux_dat = in_data1;
      2'd2:    mux_dat = in_data2;
      default: mux_dat = in_data3;
    endcase
  end

  // Single-entry output register: load on transfer, clear valid on a bare drain,
  // hold everything during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_dat;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Purpose : self-checking bench for mux_4_1_rr_arbiter (both priority builds).
// Latency : checks 1-cycle load latency and same-cycle drain+reload.
// Backpr. : exercises stalls via out_ready low, directed and random.
module tb_mux_4_1_rr_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_valid;
  logic [WIDTH-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  typedef struct packed {
    logic [1:0]       sel;
    logic [WIDTH-1:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  logic       m_valid;
  logic [1:0] m_ptr;

  always #5 clk = ~clk;

  mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] data_of(input int i);
    case (i)
      0:       return in_data0;
      1:       return in_data1;
      2:       return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // Runs one clock: checks outputs against the scoreboard/model at negedge,
  // advances the model, then returns at posedge+1 ready for new stimulus.
  task automatic cycle();
    int         g;
    logic [3:0] exp_rdy;
    logic       can_acc;
    @(negedge clk);
    g = -1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++)
      if (g < 0 && in_valid[k]) g = k;
`else
    for (int k = 1; k <= 4; k++)
      if (g < 0 && in_valid[(int'(m_ptr) + k) % 4]) g = (int'(m_ptr) + k) % 4;
`endif
    can_acc = !m_valid || out_ready;
    exp_rdy = 4'b0000;
    if (g >= 0 && can_acc) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb_q[0].dat));
        chk("out_sel", 32'(out_sel), 32'(sb_q[0].sel));
        if (out_ready && !rst) void'(sb_q.pop_front());
      end
    end
    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_ptr   = 2'd3;
    end else if (g >= 0 && can_acc) begin
      sb_q.push_back(exp_t'{sel: 2'(g), dat: data_of(g)});
      m_valid = 1'b1;
      m_ptr   = 2'(g);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rot_sel [5];
    logic [3:0] rot_dat [5];
    logic [1:0] e_sel;
`ifdef MUX_ARB_FIXED_PRIO_EN
    rot_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    rot_dat = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
`else
    rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rot_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
`endif
    m_valid   = 1'b0;
    m_ptr     = 2'd3;
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    in_data0  = 4'hA;
    in_data1  = 4'hB;
    in_data2  = 4'hC;
    in_data3  = 4'hD;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Idle after reset: nothing granted, register stays empty and zero.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_out_data", 32'(out_data), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
    end

    // All four valid, no stall: rotation 0,1,2,3,0.
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rot_sel", 32'(out_sel), 32'(rot_sel[i]));
      chk("rot_dat", 32'(out_data), 32'(rot_dat[i]));
    end

    // Stall holding a, then same-cycle drain+reload.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_dat", 32'(out_data), 32'hA);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
    chk("reload_sel", 32'(out_sel), 32'd0);
`else
    chk("reload_sel", 32'(out_sel), 32'd1);
    chk("reload_dat", 32'(out_data), 32'hB);
`endif
    in_valid = 4'b0000;
    cycle();
    chk("drained", 32'(out_valid), 32'd0);

    // Single requester 2, then 1 and 3 competing.
    in_data2 = 4'h7;
    in_valid = 4'b0100;
    cycle();
    chk("single_dat", 32'(out_data), 32'h7);
    chk("single_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b1010;
    cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
    chk("pair_first", 32'(out_sel), 32'd1);
    chk("pair_first_dat", 32'(out_data), 32'hB);
    in_valid = 4'b1000;
    e_sel = 2'd3;
`else
    chk("pair_first", 32'(out_sel), 32'd3);
    chk("pair_first_dat", 32'(out_data), 32'hD);
    in_valid = 4'b0010;
    e_sel = 2'd1;
`endif
    cycle();
    chk("pair_second", 32'(out_sel), 32'(e_sel));
    in_valid = 4'b0000;
    cycle();

    // Reset while holding c under stall discards the word.
    in_data2 = 4'hC;
    in_valid = 4'b0100;
    cycle();
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    cycle();
    chk("held_valid", 32'(out_valid), 32'd1);
    chk("held_dat", 32'(out_data), 32'hC);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_dat", 32'(out_data), 32'd0);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    cycle();
    chk("post_rst_sel", 32'(out_sel), 32'd0);

    // Requester 0 gone.
    in_valid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
      chk("no0_sel", 32'(out_sel), 32'd1);
`else
      chk("no0_sel", 32'(out_sel), 32'(i + 1));
`endif
    end

    // Random traffic with random backpressure, checked by the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data0  = 4'($urandom);
      in_data1  = 4'($urandom);
      in_data2  = 4'($urandom);
      in_data3  = 4'($urandom);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst       = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
